load_store_unit: RTL and testbench

- Sits between the execute stage and memory_unit, upstream of it; memory_unit sees only word-wide, word-aligned accesses.
- Takes one load/store request at a time, encoded with RISC-V funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- For loads, extracts the addressed byte lane and sign- or zero-extends it.
- memory_unit has no byte enables, so SB/SH are done as read-modify-write.
- Flags misaligned and illegal requests without touching memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request classification for the load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD     = 3'd1,
      S_RMW_RD = 3'd2,
      S_ST_WR  = 3'd3,
      S_RESP   = 3'd4
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Loads accept B/H/W/BU/HU; stores have no unsigned forms.
   function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3);
      if (is_store)
         return funct3[2] || (funct3 == 3'b011);
      else
         return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

   // Size lives in funct3[1:0] for both signed and unsigned forms.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and store lane merge (little-endian).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_old,
   input  logic [15:0] i_wdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_rdata,
   output logic [31:0] o_merged
);

   logic [31:0] w_shift;

   assign w_shift = i_word >> {i_addr_lo, 3'b000};

   // Extract the addressed lane(s) and sign- or zero-extend.
   always_comb begin
      o_rdata = i_word;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_BU:   o_rdata = {24'h0, w_shift[7:0]};
         F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_HU:   o_rdata = {16'h0, w_shift[15:0]};
         default: o_rdata = i_word;
      endcase
   end

   // Replace only the target lane(s) of the previously read word.
   always_comb begin
      o_merged = i_old;
      case (i_funct3[1:0])
         2'b00:   o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
         2'b01:   o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
         default: o_merged = i_old;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-only memory; sub-word stores use read-modify-write.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | ready for a request, memory strobes off
//   S_LD     | MemRead held RD_LATENCY cycles, extended data captured on last
//   S_RMW_RD | as S_LD, raw word captured for the SB/SH merge
//   S_ST_WR  | single-cycle MemWrite of merged word or SW data
//   S_RESP   | one-cycle response pulse, resp_* cleared on exit
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_misaligned,
   output logic                  resp_illegal,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   output logic                  mem_MemWrite,
   output logic                  mem_MemRead,
   input  logic [31:0]           mem_read_data
);

   localparam logic [1:0] CNT_LOAD = 2'(RD_LATENCY - 1);

   lsu_state_e            r_state;
   lsu_state_e            w_next;
   logic [1:0]            r_cnt;
   logic [2:0]            r_funct3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_merge;
   logic [31:0]           r_rdata;
   logic                  r_mis;
   logic                  r_ill;

   logic                  w_accept;
   logic                  w_ill;
   logic                  w_mis;
   logic                  w_rd_done;
   logic                  w_mem_active;
   logic [31:0]           w_ld_data;
   logic [31:0]           w_merged;

   assign w_accept  = req_valid && (r_state == S_IDLE);
   assign w_ill     = is_illegal(req_is_store, req_funct3);
   assign w_mis     = is_misaligned(req_funct3, req_addr[1:0]);
   assign w_rd_done = (r_cnt == 2'd0);

   lsu_align u_align (
      .i_word    (mem_read_data),
      .i_old     (r_merge),
      .i_wdata   (r_wdata[15:0]),
      .i_addr_lo (r_addr[1:0]),
      .i_funct3  (r_funct3),
      .o_rdata   (w_ld_data),
      .o_merged  (w_merged)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_ill || w_mis)                 w_next = S_RESP;
               else if (!req_is_store)             w_next = S_LD;
               else if (req_funct3[1:0] == 2'b10)  w_next = S_ST_WR;
               else                                w_next = S_RMW_RD;
            end
         end
         S_LD:     if (w_rd_done) w_next = S_RESP;
         S_RMW_RD: if (w_rd_done) w_next = S_ST_WR;
         S_ST_WR:  w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request latch, latency down-counter and response/merge capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= 2'd0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_merge  <= 32'd0;
         r_rdata  <= 32'd0;
         r_mis    <= 1'b0;
         r_ill    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt    <= CNT_LOAD;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_rdata  <= 32'd0;
                  r_ill    <= w_ill;
                  r_mis    <= w_mis && !w_ill;
               end
            end
            S_LD: begin
               if (w_rd_done) r_rdata <= w_ld_data;
               else           r_cnt   <= r_cnt - 2'd1;
            end
            S_RMW_RD: begin
               if (w_rd_done) r_merge <= mem_read_data;
               else           r_cnt   <= r_cnt - 2'd1;
            end
            S_RESP: begin
               r_rdata <= 32'd0;
               r_mis   <= 1'b0;
               r_ill   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign w_mem_active = (r_state == S_LD) || (r_state == S_RMW_RD) || (r_state == S_ST_WR);

   // Outputs decoded from registered state only, so strobes cannot glitch.
   always_comb begin
      req_ready       = (r_state == S_IDLE);
      resp_valid      = (r_state == S_RESP);
      resp_rdata      = r_rdata;
      resp_misaligned = r_mis;
      resp_illegal    = r_ill;
      mem_MemRead     = (r_state == S_LD) || (r_state == S_RMW_RD);
      mem_MemWrite    = (r_state == S_ST_WR);
      mem_address     = w_mem_active ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
      mem_write_data  = 32'd0;
      if (r_state == S_ST_WR)
         mem_write_data = (r_funct3[1:0] == 2'b10) ? r_wdata : w_merged;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: default instance plus an RD_LATENCY=3 instance on a shared memory.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        v1, v3;
   logic        st;
   logic [2:0]  f3;
   logic [31:0] addr, wd;

   logic        rdy1, rv1, mis1, ill1, mw1, mr1;
   logic [31:0] rd1, ma1, mwd1, rdt1;
   logic        rdy3, rv3, mis3, ill3, mw3, mr3;
   logic [31:0] rd3, ma3, mwd3, rdt3;

   logic [31:0] mem [0:15];

   assign rdt1 = mem[ma1[5:2]];
   assign rdt3 = mem[ma3[5:2]];

   always @(posedge clk) begin
      if (mw1) mem[ma1[5:2]] <= mwd1;
      if (mw3) mem[ma3[5:2]] <= mwd3;
   end

   load_store_unit #(.RD_LATENCY(1), .ADDR_WIDTH(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
      .req_is_store(st), .req_funct3(f3), .req_addr(addr), .req_wdata(wd),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_misaligned(mis1), .resp_illegal(ill1),
      .mem_address(ma1), .mem_write_data(mwd1), .mem_MemWrite(mw1), .mem_MemRead(mr1),
      .mem_read_data(rdt1)
   );

   load_store_unit #(.RD_LATENCY(3), .ADDR_WIDTH(32)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
      .req_is_store(st), .req_funct3(f3), .req_addr(addr), .req_wdata(wd),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_misaligned(mis3), .resp_illegal(ill3),
      .mem_address(ma3), .mem_write_data(mwd3), .mem_MemWrite(mw3), .mem_MemRead(mr3),
      .mem_read_data(rdt3)
   );

   int          tests = 0;
   int          fails = 0;
   int          lat, nrd, nwr, nboth;
   logic [31:0] o_rd, o_wa, o_wd;
   logic        o_mis, o_ill;
   bit          addr_stable;

   // Issue one request and observe it until resp_valid (bounded to 20 cycles).
   task automatic issue(input bit sel3, input bit s, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] w);
      logic [31:0] first_a;
      logic [31:0] a_now;
      first_a = 32'd0;
      @(negedge clk);
      st = s; f3 = f; addr = a; wd = w;
      if (sel3) v3 = 1'b1; else v1 = 1'b1;
      lat = 0; nrd = 0; nwr = 0; nboth = 0; addr_stable = 1'b1;
      o_rd = 32'hx; o_wa = 32'hx; o_wd = 32'hx; o_mis = 1'bx; o_ill = 1'bx;
      @(posedge clk);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         v1 = 1'b0; v3 = 1'b0;
         addr = 32'hDEAD_BEEF; wd = 32'hFFFF_FFFF; f3 = 3'b111; st = ~s;
         if ((sel3 ? mr3 : mr1) && (sel3 ? mw3 : mw1)) nboth++;
         if (sel3 ? mr3 : mr1) begin
            nrd++;
            a_now = sel3 ? ma3 : ma1;
            if (nrd == 1) first_a = a_now;
            else if (a_now !== first_a) addr_stable = 1'b0;
         end
         if (sel3 ? mw3 : mw1) begin
            nwr++;
            o_wa = sel3 ? ma3 : ma1;
            o_wd = sel3 ? mwd3 : mwd1;
         end
         if (sel3 ? rv3 : rv1) begin
            lat   = i;
            o_rd  = sel3 ? rd3 : rd1;
            o_mis = sel3 ? mis3 : mis1;
            o_ill = sel3 ? ill3 : ill1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({rdy1, rv1, mr1, mw1, mis1, ill1} !== 6'b100000) begin
         fails++; $display("FAIL reset_ctrl: got %b expected 100000", {rdy1, rv1, mr1, mw1, mis1, ill1});
      end
      tests++;
      if ({ma1, mwd1, rd1} !== 96'd0) begin
         fails++; $display("FAIL reset_data: got %h expected 0", {ma1, mwd1, rd1});
      end
      tests++;
      if ({rdy3, rv3, mr3, mw3} !== 4'b1000) begin
         fails++; $display("FAIL reset_lat3: got %b expected 1000", {rdy3, rv3, mr3, mw3});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sw_lw();
      issue(0, 1, F3_W, 32'h4, 32'h0000_0011);
      tests++;
      if (nwr !== 1 || nrd !== 0 || o_wa !== 32'h4 || o_wd !== 32'h11) begin
         fails++; $display("FAIL sw_write: nwr=%0d nrd=%0d addr=%h data=%h expected 1 0 4 11", nwr, nrd, o_wa, o_wd);
      end
      tests++;
      if (lat !== 2 || o_rd !== 32'd0) begin
         fails++; $display("FAIL sw_resp: lat=%0d rdata=%h expected 2 0", lat, o_rd);
      end
      issue(0, 0, F3_W, 32'h4, 32'h0);
      tests++;
      if (o_rd !== 32'h11 || lat !== 2 || nrd !== 1 || nwr !== 0) begin
         fails++; $display("FAIL lw_after_sw: rdata=%h lat=%0d nrd=%0d nwr=%0d expected 11 2 1 0", o_rd, lat, nrd, nwr);
      end
   endtask

   task automatic test_load_extend();
      logic [2:0]  tf  [5] = '{F3_B, F3_B, F3_BU, F3_H, F3_HU};
      logic [31:0] ta  [5] = '{32'h8, 32'hB, 32'hB, 32'hA, 32'hA};
      logic [31:0] te  [5] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_80FF};
      for (int k = 0; k < 5; k++) begin
         issue(0, 0, tf[k], ta[k], 32'h0);
         tests++;
         if (o_rd !== te[k] || lat !== 2 || o_mis !== 1'b0 || o_ill !== 1'b0) begin
            fails++; $display("FAIL load_ext[%0d]: rdata=%h lat=%0d expected %h 2", k, o_rd, lat, te[k]);
         end
      end
   endtask

   task automatic test_rmw();
      mem[3] = 32'h0000_0003;
      issue(0, 1, F3_B, 32'hD, 32'hFFFF_FFAB);
      tests++;
      if (nrd !== 1 || nwr !== 1 || o_wa !== 32'hC || o_wd !== 32'h0000_AB03 || lat !== 3) begin
         fails++; $display("FAIL sb_rmw: nrd=%0d nwr=%0d addr=%h data=%h lat=%0d expected 1 1 c 0000ab03 3", nrd, nwr, o_wa, o_wd, lat);
      end
      issue(0, 1, F3_H, 32'hE, 32'hFFFF_1234);
      tests++;
      if (nrd !== 1 || nwr !== 1 || o_wd !== 32'h1234_AB03 || lat !== 3) begin
         fails++; $display("FAIL sh_rmw: nrd=%0d nwr=%0d data=%h lat=%0d expected 1 1 1234ab03 3", nrd, nwr, o_wd, lat);
      end
      issue(0, 0, F3_W, 32'hC, 32'h0);
      tests++;
      if (o_rd !== 32'h1234_AB03) begin
         fails++; $display("FAIL lw_after_rmw: got %h expected 1234ab03", o_rd);
      end
   endtask

   task automatic test_faults();
      bit          ts [3] = '{1'b0, 1'b1, 1'b0};
      logic [2:0]  tf [3] = '{F3_W, F3_H, 3'b011};
      logic [31:0] ta [3] = '{32'h6, 32'h9, 32'h5};
      logic        tm [3] = '{1'b1, 1'b1, 1'b0};
      logic        ti [3] = '{1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         issue(0, ts[k], tf[k], ta[k], 32'h5555_5555);
         tests++;
         if (lat !== 1 || nrd !== 0 || nwr !== 0 || o_mis !== tm[k] || o_ill !== ti[k] || o_rd !== 32'd0) begin
            fails++; $display("FAIL fault[%0d]: lat=%0d nrd=%0d nwr=%0d mis=%b ill=%b rdata=%h expected 1 0 0 %b %b 0",
                              k, lat, nrd, nwr, o_mis, o_ill, o_rd, tm[k], ti[k]);
         end
      end
   endtask

   task automatic test_reset_mid_rmw();
      int wcnt;
      bit rdy_lost;
      wcnt = 0; rdy_lost = 1'b0;
      @(negedge clk);
      st = 1'b1; f3 = F3_B; addr = 32'hC; wd = 32'h0000_0055; v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      tests++;
      if (mr1 !== 1'b1 || rdy1 !== 1'b0) begin
         fails++; $display("FAIL rmw_rd_entered: mr=%b rdy=%b expected 1 0", mr1, rdy1);
      end
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if (mr1 !== 1'b0 || mw1 !== 1'b0 || rdy1 !== 1'b1) begin
         fails++; $display("FAIL reset_async: mr=%b mw=%b rdy=%b expected 0 0 1", mr1, mw1, rdy1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mw1) wcnt++;
         if (!rdy1) rdy_lost = 1'b1;
         if (i == 2) rst_n = 1'b1;
      end
      tests++;
      if (wcnt !== 0 || rdy_lost || mem[3] !== 32'h1234_AB03) begin
         fails++; $display("FAIL reset_no_write: writes=%0d rdy_lost=%b word=%h expected 0 0 1234ab03", wcnt, rdy_lost, mem[3]);
      end
   endtask

   task automatic test_latency3();
      issue(1, 0, F3_W, 32'h8, 32'h0);
      tests++;
      if (nrd !== 3 || !addr_stable || lat !== 4 || o_rd !== 32'h80FF_7F01 || nwr !== 0) begin
         fails++; $display("FAIL lat3_lw: nrd=%0d stable=%b lat=%0d rdata=%h expected 3 1 4 80ff7f01", nrd, addr_stable, lat, o_rd);
      end
   endtask

   initial begin
      rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; st = 1'b0; f3 = 3'b000; addr = 32'd0; wd = 32'd0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[2] = 32'h80FF_7F01;
      repeat (2) @(negedge clk);
      test_reset();
      test_sw_lw();
      test_load_extend();
      test_rmw();
      test_faults();
      test_reset_mid_rmw();
      test_latency3();
      tests++;
      if (nboth !== 0) begin
         fails++; $display("FAIL strobe_overlap: got %0d expected 0", nboth);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
